// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the shift sequencer: data/count widths, shift op
// encodings and FSM state encodings.
package shift_sequencer_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;

  // Shift operation encodings
  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  // FSM state encodings; values 6 and 7 are unused and recover to IDLE
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_S0   = 3'd1;
  localparam logic [2:0] ST_S1   = 3'd2;
  localparam logic [2:0] ST_S2   = 3'd3;
  localparam logic [2:0] ST_S3   = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between the two requesters plus consumer (master)
// and the shift sequencer (slave).
//  req_valid[1:0]  per-requester request strobe
//  req_ready[1:0]  per-requester accept, at most one bit high
//  req_in[31:0]    {in1, in0} operands
//  req_cnt[7:0]    {cnt1, cnt0} shift amounts
//  req_op[3:0]     {op1, op0} shift ops
//  out_valid       result available
//  out_ready       consumer accepts result
//  out_data[15:0]  shifted result
//  out_id          requester that issued the result
interface shift_sequencer_if;
  import shift_sequencer_pkg::*;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_in;
  logic [2*CNT_W-1:0] req_cnt;
  logic [3:0]         req_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_id;

  modport master (
    output req_valid, req_in, req_cnt, req_op, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_in, req_cnt, req_op, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

endinterface

// File: rtl/shift_sequencer_shift_stage.sv
// One stage of a logarithmic shifter: shifts by the fixed amount SHAMT when
// en is high, passes the input through otherwise.
//  in[15:0]   stage input
//  op[1:0]    rol / sll / sra / srl
//  en         apply this stage
//  out[15:0]  stage output
module shift_stage
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned SHAMT = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = in;
    case (op)
      OP_ROL:  shifted = (in << SHAMT) | (in >> (WIDTH - SHAMT));
      OP_SLL:  shifted = in << SHAMT;
      OP_SRA:  shifted = $signed(in) >>> SHAMT;
      OP_SRL:  shifted = in >> SHAMT;
      default: shifted = in;
    endcase
  end

  assign out = en ? shifted : in;

endmodule

// File: rtl/shift_sequencer.sv
// Shares one four-stage logarithmic shifter between two requesters. One stage
// runs per cycle (IDLE -> S0 -> S1 -> S2 -> S3 -> DONE -> IDLE), requesters
// are served round-robin, and the result is returned with valid/ready tagged
// by requester id.
//  clk    clock, all state on rising edge
//  rst_n  synchronous reset, active-low
//  bus    request/result bundle (slave side)
//  busy   high in any state other than IDLE
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  shift_sequencer_if.slave   bus,
  output logic               busy
);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_id_q, out_id_d;

  logic             grant_any;
  logic             grant_id;
  logic [WIDTH-1:0] stage_out [4];

  // All four stages see the working register; the FSM picks the one for the
  // current state.
  for (genvar k = 0; k < 4; k++) begin : g_stage
    shift_stage #(
      .SHAMT(1 << k)
    ) u_stage (
      .in (data_q),
      .op (op_q),
      .en (cnt_q[k]),
      .out(stage_out[k])
    );
  end

  // Round-robin arbiter, only active in IDLE
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state_q == ST_IDLE) begin
      case (bus.req_valid)
        2'b01: begin
          grant_any = 1'b1;
          grant_id  = 1'b0;
        end
        2'b10: begin
          grant_any = 1'b1;
          grant_id  = 1'b1;
        end
        2'b11: begin
          grant_any = 1'b1;
          grant_id  = ~last_grant_q;
        end
        default: begin
          grant_any = 1'b0;
          grant_id  = 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = grant_any ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          data_d       = grant_id ? bus.req_in[31:16] : bus.req_in[15:0];
          cnt_d        = grant_id ? bus.req_cnt[7:4] : bus.req_cnt[3:0];
          op_d         = grant_id ? bus.req_op[3:2] : bus.req_op[1:0];
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = ST_S0;
        end
      end
      ST_S0: begin
        data_d  = stage_out[0];
        state_d = ST_S1;
      end
      ST_S1: begin
        data_d  = stage_out[1];
        state_d = ST_S2;
      end
      ST_S2: begin
        data_d  = stage_out[2];
        state_d = ST_S3;
      end
      ST_S3: begin
        // Result goes to a separate register so it survives the next grant
        data_d     = stage_out[3];
        out_data_d = stage_out[3];
        out_id_d   = id_q;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      cnt_q        <= '0;
      op_q         <= OP_ROL;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      out_data_q   <= '0;
      out_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
    end
  end

  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
